// File: rtl/sprite_pkg.sv
// sprite_pkg: shared definitions for the sprite line scanner.
//   - coordinate/offset widths and sprite size
//   - world_type encodings and sprite entry field positions
//   - decode_x / decode_y / decode_id entry field extractors
//   - scan FSM state encoding and the line-list slot record
package sprite_pkg;

  localparam int COORD_W     = 13;
  localparam int SPRITE_SIZE = 16;
  localparam int OFF_W       = $clog2(SPRITE_SIZE);
  localparam int ID_W        = 9;

  // Entry layout: {id[31:23], packed x/y[22:0]}
  localparam int ENTRY_ID_MSB = 31;
  localparam int ENTRY_ID_LSB = 23;
  localparam int ENTRY_XY_MSB = 22;

  // Coordinate arithmetic is done one bit wider so a set MSB flags a negative difference.
  typedef logic [COORD_W:0] coord1_t;

  typedef enum logic [1:0] {
    WT_X13_Y10 = 2'b00,  // x=[22:10], y=[9:0]
    WT_X10_Y13 = 2'b01,  // x=[22:13], y=[12:0]
    WT_X12_Y11 = 2'b10,  // x=[22:11], y=[10:0]
    WT_ZERO    = 2'b11   // x=y=0
  } world_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

  typedef struct packed {
    logic                   valid;
    logic [ID_W-1:0]        id;
    logic [COORD_W-1:0]     x;
    logic [OFF_W-1:0]       row;
  } slot_t;

  function automatic logic [ID_W-1:0] decode_id(input logic [31:0] e);
    return e[ENTRY_ID_MSB:ENTRY_ID_LSB];
  endfunction

  function automatic logic [COORD_W-1:0] decode_x(input logic [31:0] e, input world_type_e wt);
    logic [COORD_W-1:0] r;
    r = {COORD_W{1'b0}};
    case (wt)
      WT_X13_Y10: r = e[ENTRY_XY_MSB:10];
      WT_X10_Y13: r = {3'b000, e[ENTRY_XY_MSB:13]};
      WT_X12_Y11: r = {1'b0, e[ENTRY_XY_MSB:11]};
      default:    r = {COORD_W{1'b0}};
    endcase
    return r;
  endfunction

  function automatic logic [COORD_W-1:0] decode_y(input logic [31:0] e, input world_type_e wt);
    logic [COORD_W-1:0] r;
    r = {COORD_W{1'b0}};
    case (wt)
      WT_X13_Y10: r = {3'b000, e[9:0]};
      WT_X10_Y13: r = e[12:0];
      WT_X12_Y11: r = {2'b00, e[10:0]};
      default:    r = {COORD_W{1'b0}};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sprite_slot_match.sv
// sprite_slot_match: per-pixel test of one line-list slot.
//   slot_i    : slot record {valid, id, x, row}
//   world_x_i : pixel X in world space (COORD_W+1 bits)
//   hit_o     : slot valid and 0 <= world_x - x < SPRITE_SIZE
//   off_x_o   : column offset inside the sprite
//   row_o     : row offset inside the sprite (captured during the scan)
//   border_o  : column or row lies on the sprite edge
module sprite_slot_match
  import sprite_pkg::*;
(
  input  slot_t            slot_i,
  input  logic [COORD_W:0] world_x_i,
  output logic             hit_o,
  output logic [OFF_W-1:0] off_x_o,
  output logic [OFF_W-1:0] row_o,
  output logic             border_o
);

  localparam logic [OFF_W-1:0] EDGE_MAX = OFF_W'(SPRITE_SIZE - 1);
  localparam logic [OFF_W-1:0] EDGE_MIN = {OFF_W{1'b0}};

  logic [COORD_W:0] dx_s;

  assign dx_s = world_x_i - {1'b0, slot_i.x};

  // Upper bits zero covers both "not negative" and "below SPRITE_SIZE".
  assign hit_o    = slot_i.valid && (dx_s[COORD_W:OFF_W] == {(COORD_W + 1 - OFF_W){1'b0}});
  assign off_x_o  = dx_s[OFF_W-1:0];
  assign row_o    = slot_i.row;
  assign border_o = (off_x_o == EDGE_MIN) || (off_x_o == EDGE_MAX) ||
                    (row_o == EDGE_MIN) || (row_o == EDGE_MAX);

endmodule

// File: rtl/sprite_line_scanner.sv
// sprite_line_scanner: per-scanline sprite evaluator.
//   Register slave : write/address/writedata fill the back sprite bank and the
//                    shadow offset_x/offset_y/world_type registers; commit arms a swap.
//   frame_start    : swaps banks and loads shadows when a commit is pending.
//   line_start     : activates the list built for this line and scans the table
//                    (one entry per cycle) for sprites on next_line_y.
//   pixel_x/valid  : matched against the active list; pix_* registered one cycle later.
//   scan_busy, line_overflow, line_truncated, frame_committed: status outputs.
module sprite_line_scanner
  import sprite_pkg::*;
#(
  parameter int SPRITE_COUNT = 64,
  parameter int MAX_PER_LINE = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             write,
  input  logic [7:0]       address,
  input  logic [31:0]      writedata,
  input  logic             frame_start,
  input  logic             line_start,
  input  logic [8:0]       next_line_y,
  input  logic [9:0]       pixel_x,
  input  logic             pixel_valid,
  output logic             pix_hit,
  output logic [ID_W-1:0]  pix_id,
  output logic [OFF_W-1:0] pix_off_x,
  output logic [OFF_W-1:0] pix_off_y,
  output logic             pix_border,
  output logic             pix_overlap,
  output logic             scan_busy,
  output logic             line_overflow,
  output logic             line_truncated,
  output logic             frame_committed
);

  localparam int IDX_W = $clog2(SPRITE_COUNT);
  localparam int CNT_W = $clog2(MAX_PER_LINE + 1);
  localparam logic [7:0] ADDR_OFFX   = 8'(SPRITE_COUNT);
  localparam logic [7:0] ADDR_OFFY   = 8'(SPRITE_COUNT + 1);
  localparam logic [7:0] ADDR_WTYPE  = 8'(SPRITE_COUNT + 2);
  localparam logic [7:0] ADDR_COMMIT = 8'(SPRITE_COUNT + 3);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SPRITE_COUNT - 1);

  // Register file and commit state
  logic [31:0]          bank_q [2][SPRITE_COUNT];
  logic                 front_q;
  logic [COORD_W-1:0]   offx_q, offy_q, offx_sh_q, offy_sh_q;
  world_type_e          wt_q, wt_sh_q;
  logic                 commit_pending_q;
  logic                 frame_committed_q;
  logic                 swap_s;
  logic                 entry_wr_s;
  logic [COORD_W-1:0]   offy_eff_s;

  // Scan FSM state
  scan_state_e                    state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  coord1_t                        wy_q, wy_d;
  slot_t [MAX_PER_LINE-1:0]       build_q, build_d, active_q, active_d, build_upd_s;
  logic [CNT_W-1:0]               bcnt_q, bcnt_d, bcnt_upd_s;
  logic                           bovf_q, bovf_d, bovf_upd_s;
  logic                           line_ovf_q, line_ovf_d, line_trunc_q, line_trunc_d;
  logic [31:0]                    entry_s;
  coord1_t                        dy_s, wy_start_s;
  logic                           cand_s;
  slot_t                          new_slot_s;

  // Pixel match
  coord1_t                        world_x_s;
  logic [MAX_PER_LINE-1:0]        hit_s;
  logic [OFF_W-1:0]               offx_s   [MAX_PER_LINE];
  logic [OFF_W-1:0]               row_s    [MAX_PER_LINE];
  logic [MAX_PER_LINE-1:0]        border_s;
  logic                           any_hit_s, overlap_s, win_border_s;
  logic [ID_W-1:0]                win_id_s;
  logic [OFF_W-1:0]               win_offx_s, win_row_s;
  logic [CNT_W-1:0]               nhit_s;
  logic                           pix_hit_q, pix_border_q, pix_overlap_q;
  logic [ID_W-1:0]                pix_id_q;
  logic [OFF_W-1:0]               pix_off_x_q, pix_off_y_q;

  assign swap_s     = frame_start && commit_pending_q;
  assign entry_wr_s = write && (address < ADDR_OFFX);
  // A swap in the same cycle as line_start must already feed the new offset_y.
  assign offy_eff_s = swap_s ? offy_sh_q : offy_q;
  assign wy_start_s = coord1_t'(next_line_y) + coord1_t'(offy_eff_s);

  // Sprite banks, shadow/active registers and commit handshake.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int e = 0; e < SPRITE_COUNT; e++) begin
          bank_q[b][e] <= 32'd0;
        end
      end
      front_q           <= 1'b0;
      offx_q            <= {COORD_W{1'b0}};
      offy_q            <= {COORD_W{1'b0}};
      offx_sh_q         <= {COORD_W{1'b0}};
      offy_sh_q         <= {COORD_W{1'b0}};
      wt_q              <= WT_X13_Y10;
      wt_sh_q           <= WT_X13_Y10;
      commit_pending_q  <= 1'b0;
      frame_committed_q <= 1'b0;
    end else begin
      if (entry_wr_s) begin
        bank_q[~front_q][address[IDX_W-1:0]] <= writedata;
      end
      if (write) begin
        case (address)
          ADDR_OFFX:  offx_sh_q <= writedata[COORD_W-1:0];
          ADDR_OFFY:  offy_sh_q <= writedata[COORD_W-1:0];
          ADDR_WTYPE: wt_sh_q   <= world_type_e'(writedata[1:0]);
          default:    ;
        endcase
      end
      if (swap_s) begin
        front_q <= ~front_q;
        offx_q  <= offx_sh_q;
        offy_q  <= offy_sh_q;
        wt_q    <= wt_sh_q;
      end
      // A commit written alongside frame_start survives to the next frame.
      if (write && (address == ADDR_COMMIT)) begin
        commit_pending_q <= 1'b1;
      end else if (frame_start) begin
        commit_pending_q <= 1'b0;
      end
      frame_committed_q <= swap_s;
    end
  end

  // Candidate test of the entry read this cycle and its insertion into the build list.
  always_comb begin
    entry_s     = bank_q[front_q][idx_q];
    dy_s        = wy_q - {1'b0, decode_y(entry_s, wt_q)};
    cand_s      = (state_q == ST_SCAN) && (decode_id(entry_s) != {ID_W{1'b0}}) &&
                  (dy_s[COORD_W:OFF_W] == {(COORD_W + 1 - OFF_W){1'b0}});
    new_slot_s  = '{valid: 1'b1, id: decode_id(entry_s), x: decode_x(entry_s, wt_q),
                    row: dy_s[OFF_W-1:0]};
    build_upd_s = build_q;
    bcnt_upd_s  = bcnt_q;
    bovf_upd_s  = bovf_q;
    if (cand_s) begin
      if (bcnt_q < CNT_W'(MAX_PER_LINE)) begin
        for (int s = 0; s < MAX_PER_LINE; s++) begin
          if (bcnt_q == CNT_W'(s)) begin
            build_upd_s[s] = new_slot_s;
          end else begin
            build_upd_s[s] = build_q[s];
          end
        end
        bcnt_upd_s = bcnt_q + CNT_W'(1);
      end else begin
        bovf_upd_s = 1'b1;
      end
    end else begin
      bovf_upd_s = bovf_q;
    end
  end

  // Scan FSM next state: list hand-over on line_start, entry walk during SCAN.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wy_d         = wy_q;
    build_d      = build_q;
    bcnt_d       = bcnt_q;
    bovf_d       = bovf_q;
    active_d     = active_q;
    line_ovf_d   = line_ovf_q;
    line_trunc_d = line_trunc_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (line_start) begin
          active_d     = build_q;
          line_ovf_d   = bovf_q;
          line_trunc_d = 1'b0;
          build_d      = '0;
          bcnt_d       = {CNT_W{1'b0}};
          bovf_d       = 1'b0;
          idx_d        = {IDX_W{1'b0}};
          wy_d         = wy_start_s;
          state_d      = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (line_start) begin
          // The entry read this cycle still counts towards the truncated list.
          active_d     = build_upd_s;
          line_ovf_d   = bovf_upd_s;
          line_trunc_d = 1'b1;
          build_d      = '0;
          bcnt_d       = {CNT_W{1'b0}};
          bovf_d       = 1'b0;
          idx_d        = {IDX_W{1'b0}};
          wy_d         = wy_start_s;
          state_d      = ST_SCAN;
        end else begin
          build_d = build_upd_s;
          bcnt_d  = bcnt_upd_s;
          bovf_d  = bovf_upd_s;
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Scan FSM and line-list registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= {IDX_W{1'b0}};
      wy_q         <= '0;
      build_q      <= '0;
      bcnt_q       <= {CNT_W{1'b0}};
      bovf_q       <= 1'b0;
      active_q     <= '0;
      line_ovf_q   <= 1'b0;
      line_trunc_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wy_q         <= wy_d;
      build_q      <= build_d;
      bcnt_q       <= bcnt_d;
      bovf_q       <= bovf_d;
      active_q     <= active_d;
      line_ovf_q   <= line_ovf_d;
      line_trunc_q <= line_trunc_d;
    end
  end

  assign world_x_s = coord1_t'(pixel_x) + coord1_t'(offx_q);

  for (genvar g = 0; g < MAX_PER_LINE; g++) begin : g_slot
    sprite_slot_match u_match (
      .slot_i    (active_q[g]),
      .world_x_i (world_x_s),
      .hit_o     (hit_s[g]),
      .off_x_o   (offx_s[g]),
      .row_o     (row_s[g]),
      .border_o  (border_s[g])
    );
  end

  // Priority encoder: walking down leaves the lowest hitting slot as the winner.
  always_comb begin
    any_hit_s    = 1'b0;
    win_id_s     = {ID_W{1'b0}};
    win_offx_s   = {OFF_W{1'b0}};
    win_row_s    = {OFF_W{1'b0}};
    win_border_s = 1'b0;
    nhit_s       = {CNT_W{1'b0}};
    for (int s = MAX_PER_LINE - 1; s >= 0; s--) begin
      nhit_s = nhit_s + CNT_W'(hit_s[s]);
      if (hit_s[s]) begin
        any_hit_s    = 1'b1;
        win_id_s     = active_q[s].id;
        win_offx_s   = offx_s[s];
        win_row_s    = row_s[s];
        win_border_s = border_s[s];
      end else begin
        any_hit_s    = any_hit_s;
      end
    end
    overlap_s = (nhit_s > CNT_W'(1));
  end

  // Pixel output register; everything reads zero off-screen or on a miss.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pix_hit_q     <= 1'b0;
      pix_id_q      <= {ID_W{1'b0}};
      pix_off_x_q   <= {OFF_W{1'b0}};
      pix_off_y_q   <= {OFF_W{1'b0}};
      pix_border_q  <= 1'b0;
      pix_overlap_q <= 1'b0;
    end else if (pixel_valid && any_hit_s) begin
      pix_hit_q     <= 1'b1;
      pix_id_q      <= win_id_s;
      pix_off_x_q   <= win_offx_s;
      pix_off_y_q   <= win_row_s;
      pix_border_q  <= win_border_s;
      pix_overlap_q <= overlap_s;
    end else begin
      pix_hit_q     <= 1'b0;
      pix_id_q      <= {ID_W{1'b0}};
      pix_off_x_q   <= {OFF_W{1'b0}};
      pix_off_y_q   <= {OFF_W{1'b0}};
      pix_border_q  <= 1'b0;
      pix_overlap_q <= 1'b0;
    end
  end

  assign pix_hit         = pix_hit_q;
  assign pix_id          = pix_id_q;
  assign pix_off_x       = pix_off_x_q;
  assign pix_off_y       = pix_off_y_q;
  assign pix_border      = pix_border_q;
  assign pix_overlap     = pix_overlap_q;
  assign scan_busy       = (state_q == ST_SCAN);
  assign line_overflow   = line_ovf_q;
  assign line_truncated  = line_trunc_q;
  assign frame_committed = frame_committed_q;

endmodule

// File: tb/tb_sprite_line_scanner.sv
module tb_sprite_line_scanner;
  import sprite_pkg::*;

  localparam int SC = 64;

  logic        clk = 1'b0;
  logic        reset_n, write, frame_start, line_start, pixel_valid;
  logic [7:0]  address;
  logic [31:0] writedata;
  logic [8:0]  next_line_y;
  logic [9:0]  pixel_x;
  logic        pix_hit, pix_border, pix_overlap, scan_busy, line_overflow, line_truncated, frame_committed;
  logic [8:0]  pix_id;
  logic [3:0]  pix_off_x, pix_off_y;

  always #5 clk = ~clk;

  sprite_line_scanner #(.SPRITE_COUNT(SC), .MAX_PER_LINE(8)) dut (
    .clk(clk), .reset_n(reset_n), .write(write), .address(address), .writedata(writedata),
    .frame_start(frame_start), .line_start(line_start), .next_line_y(next_line_y),
    .pixel_x(pixel_x), .pixel_valid(pixel_valid), .pix_hit(pix_hit), .pix_id(pix_id),
    .pix_off_x(pix_off_x), .pix_off_y(pix_off_y), .pix_border(pix_border),
    .pix_overlap(pix_overlap), .scan_busy(scan_busy), .line_overflow(line_overflow),
    .line_truncated(line_truncated), .frame_committed(frame_committed)
  );

  typedef struct {
    logic [9:0] px;
    logic       pv;
    logic       hit;
    logic [8:0] id;
    logic [3:0] ox;
    logic [3:0] oy;
    logic       bd;
    logic       ov;
  } pvec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  pvec_t       sb_q[$];
  pvec_t       vec1[19];
  logic [31:0] tbl[SC];

  function automatic pvec_t mkv(input int px, input logic pv, input logic hit, input int id,
                                input int ox, input int oy, input logic bd, input logic ov);
    pvec_t v;
    v.px = 10'(px); v.pv = pv; v.hit = hit; v.id = 9'(id);
    v.ox = 4'(ox); v.oy = 4'(oy); v.bd = bd; v.ov = ov;
    return v;
  endfunction

  function automatic logic [31:0] mk00(input int id, input int x, input int y);
    return {9'(id), 13'(x), 10'(y)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    write = 1'b1; address = 8'(a); writedata = d;
    tick();
    write = 1'b0;
  endtask

  task automatic load_table();
    for (int i = 0; i < SC; i++) wr(i, tbl[i]);
  endtask

  task automatic commit_frame(input string nm);
    wr(SC + 3, 32'd1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check({nm, ".committed"}, frame_committed, 1'b1);
    tick();
    check({nm, ".committed_drop"}, frame_committed, 1'b0);
  endtask

  task automatic line(input int y);
    line_start = 1'b1; next_line_y = 9'(y);
    tick();
    line_start = 1'b0;
    repeat (SC + 2) tick();
  endtask

  // Drive one pixel, queue its expectation, compare when the registered result appears.
  task automatic pix(input string nm, input pvec_t v);
    pvec_t e;
    pixel_x = v.px; pixel_valid = v.pv;
    sb_q.push_back(v);
    tick();
    pixel_valid = 1'b0;
    e = sb_q.pop_front();
    check({nm, ".hit"}, pix_hit, e.hit);
    check({nm, ".id"}, pix_id, e.id);
    check({nm, ".off_x"}, pix_off_x, e.ox);
    check({nm, ".off_y"}, pix_off_y, e.oy);
    check({nm, ".border"}, pix_border, e.bd);
    check({nm, ".overlap"}, pix_overlap, e.ov);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) vec1[i] = mkv(100 + i, 1'b1, 1'b1, 5, i, 0, 1'b1, 1'b0);
    vec1[16] = mkv(99, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    vec1[17] = mkv(116, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    vec1[18] = mkv(100, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);

    reset_n = 1'b0; write = 1'b0; address = 8'd0; writedata = 32'd0; frame_start = 1'b0;
    line_start = 1'b0; next_line_y = 9'd0; pixel_x = 10'd0; pixel_valid = 1'b0;
    repeat (3) tick();
    check("rst.pix_hit", pix_hit, 1'b0);
    check("rst.pix_id", pix_id, 9'd0);
    check("rst.scan_busy", scan_busy, 1'b0);
    check("rst.overflow", line_overflow, 1'b0);
    check("rst.truncated", line_truncated, 1'b0);
    check("rst.committed", frame_committed, 1'b0);
    reset_n = 1'b1;
    tick();

    // frame_start without commit: no swap, nothing on screen
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("nocommit.committed", frame_committed, 1'b0);
    line(40);
    line(40);
    pix("nocommit.px100", mkv(100, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0));

    // Single sprite, world_type 00
    for (int i = 0; i < SC; i++) tbl[i] = 32'd0;
    tbl[0] = mk00(5, 100, 40);
    load_table();
    wr(SC + 2, 32'd0); wr(SC + 0, 32'd0); wr(SC + 1, 32'd0);
    commit_frame("single");
    line(40);
    line(200);
    check("single.overflow", line_overflow, 1'b0);
    check("single.truncated", line_truncated, 1'b0);
    for (int i = 0; i < 19; i++) pix($sformatf("single.v%0d", i), vec1[i]);
    line(47);
    line(0);
    pix("row7.x101", mkv(101, 1'b1, 1'b1, 5, 1, 7, 1'b0, 1'b0));
    pix("row7.x100", mkv(100, 1'b1, 1'b1, 5, 0, 7, 1'b1, 1'b0));

    // Overlap, overflow and truncation table
    for (int i = 0; i < SC; i++) tbl[i] = 32'd0;
    tbl[3] = mk00(9, 300, 100);
    tbl[7] = mk00(12, 300, 100);
    for (int i = 10; i < 20; i++) tbl[i] = mk00(20 + i, 400 + 16 * (i - 10), 150);
    tbl[8]  = mk00(40, 700, 60);
    tbl[30] = mk00(41, 720, 60);
    load_table();
    commit_frame("multi");
    line(150);
    line(100);
    check("ovf.flag", line_overflow, 1'b1);
    pix("ovf.e10", mkv(400, 1'b1, 1'b1, 30, 0, 0, 1'b1, 1'b0));
    pix("ovf.e17", mkv(515, 1'b1, 1'b1, 37, 3, 0, 1'b1, 1'b0));
    pix("ovf.e18", mkv(528, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0));
    pix("ovf.e19", mkv(545, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0));
    line(0);
    check("ovf.clear", line_overflow, 1'b0);
    pix("ovl.x300", mkv(300, 1'b1, 1'b1, 9, 0, 0, 1'b1, 1'b1));
    pix("ovl.x305", mkv(305, 1'b1, 1'b1, 9, 5, 0, 1'b1, 1'b1));

    // Second line_start ten cycles after the first
    line_start = 1'b1; next_line_y = 9'd60;
    tick();
    line_start = 1'b0;
    repeat (9) tick();
    line_start = 1'b1; next_line_y = 9'd60;
    tick();
    line_start = 1'b0;
    check("trunc.flag", line_truncated, 1'b1);
    check("trunc.busy_start", scan_busy, 1'b1);
    pix("trunc.e8", mkv(700, 1'b1, 1'b1, 40, 0, 0, 1'b1, 1'b0));
    pix("trunc.e30", mkv(720, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0));
    repeat (61) tick();
    check("trunc.busy_end", scan_busy, 1'b1);
    tick();
    check("trunc.busy_drop", scan_busy, 1'b0);
    line(0);
    check("trunc.clear", line_truncated, 1'b0);
    pix("full.e30", mkv(720, 1'b1, 1'b1, 41, 0, 0, 1'b1, 1'b0));

    // Offsets: x offset at commit, y offset shadowed until the next commit
    for (int i = 0; i < SC; i++) tbl[i] = 32'd0;
    tbl[0] = mk00(50, 610, 200);
    load_table();
    wr(SC + 0, 32'd600); wr(SC + 1, 32'd0);
    commit_frame("offs");
    line(200);
    line(0);
    pix("offs.x9", mkv(9, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0));
    pix("offs.x10", mkv(10, 1'b1, 1'b1, 50, 0, 0, 1'b1, 1'b0));
    pix("offs.x25", mkv(25, 1'b1, 1'b1, 50, 15, 0, 1'b1, 1'b0));
    pix("offs.x26", mkv(26, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0));
    wr(SC + 1, 32'd50);
    line(200);
    line(0);
    pix("shadow.x17", mkv(17, 1'b1, 1'b1, 50, 7, 0, 1'b1, 1'b0));
    load_table();
    commit_frame("offy");
    line(150);
    line(0);
    pix("offy.x17", mkv(17, 1'b1, 1'b1, 50, 7, 0, 1'b1, 1'b0));

    // world_type 10 decode
    for (int i = 0; i < SC; i++) tbl[i] = 32'd0;
    tbl[0] = {9'd60, 12'd900, 11'd300};
    load_table();
    wr(SC + 2, 32'd2); wr(SC + 0, 32'd0); wr(SC + 1, 32'd0);
    commit_frame("wt10");
    line(300);
    line(0);
    pix("wt10.x900", mkv(900, 1'b1, 1'b1, 60, 0, 0, 1'b1, 1'b0));
    pix("wt10.x899", mkv(899, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
